wb_master_bridge: RTL and testbench

WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_master_bridge_if.sv | 35 +++
 rtl/wb_master_bridge.sv | 127 ++++++++++++
 tb/tb_wb_master_bridge.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Types and width helpers shared by the Wishbone master bridge, its bus interface
// and anything that inspects the bridge state.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int BYTE_W = 8;

    function automatic int sel_width(input int data_w);
        return data_w / BYTE_W;
    endfunction

    // Number of address bits that select a byte lane inside one bus word.
    function automatic int adr_lsb(input int data_w);
        return (data_w > BYTE_W) ? $clog2(data_w / BYTE_W) : 0;
    endfunction

endpackage

// File: rtl/wb_master_bridge_if.sv
// Wishbone bus bundle between the bridge (master modport) and a slave (slave modport).
interface wb_master_bridge_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    import wb_pkg::*;

    localparam int SEL_W = sel_width(DATA_W);

    // Handshake: the core holds core_req_i (valid) with stable fields until the
    // one-cycle core_ready_o pulse. On the bus, a strobe is accepted in a cycle with
    // wb_stb_o=1 and wb_stall_i=0 (pipelined only); wb_ack_i or wb_err_i in a cycle
    // with wb_cyc_o=1 terminates the transfer, err taking priority over ack.
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [DATA_W-1:0] wb_dat_o;
    logic [SEL_W-1:0]  wb_sel_o;
    logic              wb_ack_i;
    logic              wb_err_i;
    logic              wb_stall_i;
    logic [DATA_W-1:0] wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_ack_i, wb_err_i, wb_stall_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_ack_i, wb_err_i, wb_stall_i, wb_dat_i
    );

endinterface

// File: rtl/wb_master_bridge.sv
// Single-outstanding core-to-Wishbone master bridge, classic or B4 pipelined,
// with an optional bus-cycle timeout that completes the request with an error.
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int PIPELINED = 0,
    parameter int TIMEOUT   = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     core_req_i,
    input  logic                     core_we_i,
    input  logic [ADDR_W-1:0]        core_addr_i,
    input  logic [DATA_W-1:0]        core_wdata_i,
    input  logic [DATA_W/8-1:0]      core_be_i,
    output logic                     core_ready_o,
    output logic [DATA_W-1:0]        core_rdata_o,
    output logic                     core_err_o,
    wb_master_bridge_if.master       wb,
    output state_t                   dbg_state_o
);

    localparam int SEL_W = sel_width(DATA_W);
    localparam int LSB   = adr_lsb(DATA_W);
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ADDR_W-1:0] ADR_MASK = ~ADDR_W'((1 << LSB) - 1);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (core_req_i) begin
                    we_d  = core_we_i;
                    adr_d = core_addr_i & ADR_MASK;
                    dat_d = core_wdata_i;
                    sel_d = core_we_i ? core_be_i : '1;
                    tmo_d = '0;
                    // A write that touches no byte lane completes without a bus cycle.
                    if (core_we_i && (core_be_i == '0)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b0;
                        rdata_d = '0;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ, ST_WAIT: begin
                if (wb.wb_err_i) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (wb.wb_ack_i) begin
                    state_d = ST_DONE;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : wb.wb_dat_i;
                end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if ((state_q == ST_REQ) && (PIPELINED != 0) && !wb.wb_stall_i) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign core_ready_o = (state_q == ST_DONE);
    assign core_err_o   = core_ready_o & err_q;
    assign core_rdata_o = rdata_q;

    assign wb.wb_cyc_o  = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign wb.wb_stb_o  = (state_q == ST_REQ);
    assign wb.wb_we_o   = we_q;
    assign wb.wb_adr_o  = adr_q;
    assign wb.wb_dat_o  = dat_q;
    assign wb.wb_sel_o  = sel_q;

    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: a classic and a pipelined instance, transaction-level
// expected timelines, per-cycle output comparison and a few literal scenario checks.
module tb_wb_master_bridge;
    import wb_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    typedef struct packed {
        logic          cyc;
        logic          stb;
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        logic          ready;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [SW-1:0] core_be;

    logic          rdy_c, err_c, rdy_p, err_p;
    logic [DW-1:0] rdata_c, rdata_p;
    state_t        dbg_c, dbg_p;

    wb_master_bridge_if #(.DATA_W(DW), .ADDR_W(AW)) if_c ();
    wb_master_bridge_if #(.DATA_W(DW), .ADDR_W(AW)) if_p ();

    wb_master_bridge #(.DATA_W(DW), .ADDR_W(AW), .PIPELINED(0), .TIMEOUT(TMO)) dut_c (
        .clk(clk), .rst(rst),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_be_i(core_be),
        .core_ready_o(rdy_c), .core_rdata_o(rdata_c), .core_err_o(err_c),
        .wb(if_c.master), .dbg_state_o(dbg_c)
    );

    wb_master_bridge #(.DATA_W(DW), .ADDR_W(AW), .PIPELINED(1), .TIMEOUT(TMO)) dut_p (
        .clk(clk), .rst(rst),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_be_i(core_be),
        .core_ready_o(rdy_p), .core_rdata_o(rdata_p), .core_err_o(err_p),
        .wb(if_p.master), .dbg_state_o(dbg_p)
    );

    // ---------------- model state and scoreboard ----------------
    exp_t          exp_q[$];
    logic          pip = 1'b0;
    int            total = 0;
    int            bad = 0;
    int            cyc_n = 0;
    logic          m_we;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat;
    logic [SW-1:0] m_sel;
    logic [DW-1:0] m_rdata;

    // observations of the selected DUT, used by the literal scenario checks
    int            stb_cnt = 0, cyc_cnt = 0, rdy_cnt = 0, rdy_cyc = 0;
    logic          rdy_err;
    logic [DW-1:0] rdy_rdata;
    logic [AW-1:0] stb_adr;
    logic [SW-1:0] stb_sel;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic exp_t mk(input logic cyc, input logic stb, input logic ready, input logic err);
        exp_t x;
        x.cyc   = cyc;
        x.stb   = stb;
        x.we    = m_we;
        x.adr   = m_adr;
        x.dat   = m_dat;
        x.sel   = m_sel;
        x.ready = ready;
        x.err   = err;
        x.rdata = m_rdata;
        return x;
    endfunction

    always @(negedge clk) begin
        exp_t e, got_c, got_p, got;
        got_c = {if_c.wb_cyc_o, if_c.wb_stb_o, if_c.wb_we_o, if_c.wb_adr_o, if_c.wb_dat_o,
                 if_c.wb_sel_o, rdy_c, err_c, rdata_c};
        got_p = {if_p.wb_cyc_o, if_p.wb_stb_o, if_p.wb_we_o, if_p.wb_adr_o, if_p.wb_dat_o,
                 if_p.wb_sel_o, rdy_p, err_p, rdata_p};
        got = pip ? got_p : got_c;
        if (got.stb) begin
            stb_cnt++;
            stb_adr = got.adr;
            stb_sel = got.sel;
        end
        if (got.cyc) cyc_cnt++;
        if (got.ready) begin
            rdy_cnt++;
            rdy_cyc   = cyc_n;
            rdy_err   = got.err;
            rdy_rdata = got.rdata;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL outputs cycle=%0d pip=%0d got=%h exp=%h", cyc_n, pip, got, e);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slave(input logic ack, input logic err, input logic stall, input logic [DW-1:0] dat);
        if_c.wb_ack_i = ack;  if_c.wb_err_i = err;  if_c.wb_stall_i = stall;  if_c.wb_dat_i = dat;
        if_p.wb_ack_i = ack;  if_p.wb_err_i = err;  if_p.wb_stall_i = stall;  if_p.wb_dat_i = dat;
    endtask

    task automatic noise();
        set_slave(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));
    endtask

    task automatic model_clear();
        m_we = 1'b0;  m_adr = '0;  m_dat = '0;  m_sel = '0;  m_rdata = '0;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        core_req = 1'b0;
        set_slave(1'b0, 1'b0, 1'b0, '0);
        next_cycle();
        rst = 1'b0;
        model_clear();
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        chk("reset_state_c", 64'(dbg_c), 64'(ST_IDLE));
        chk("reset_state_p", 64'(dbg_p), 64'(ST_IDLE));
    endtask

    // kind: 0 ack, 1 err, 2 ack+err, 3 silent slave; r: bus cycle of the response;
    // stall_n: leading bus cycles with stall high.
    task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [SW-1:0] be, input int kind, input int r, input int stall_n,
                          input logic [DW-1:0] rd, output int req_cyc);
        logic resp_ends, x_err, st;
        int   e;
        next_cycle();
        core_req = 1'b1;  core_we = we;  core_addr = addr;  core_wdata = wd;  core_be = be;
        noise();
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
        req_cyc = cyc_n;
        m_we  = we;
        m_adr = addr & ~AW'(SW - 1);
        m_dat = wd;
        m_sel = we ? be : '1;
        if (we && (be == '0)) begin
            next_cycle();
            noise();
            m_rdata = '0;
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
        end else begin
            resp_ends = (kind != 3) && (r <= TMO - 1);
            e         = resp_ends ? r : TMO - 1;
            x_err     = !resp_ends || (kind != 0);
            for (int k = 0; k <= e; k++) begin
                next_cycle();
                st = (k < stall_n) ? 1'b1 : ((k == stall_n) ? 1'b0 : 1'($urandom_range(0, 1)));
                set_slave((kind == 0 || kind == 2) && (k == r), (kind == 1 || kind == 2) && (k == r),
                          st, (k == r) ? rd : DW'($urandom));
                exp_q.push_back(mk(1'b1, pip ? (k <= stall_n) : 1'b1, 1'b0, 1'b0));
            end
            next_cycle();
            noise();
            m_rdata = (x_err || we) ? '0 : rd;
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, x_err));
        end
        next_cycle();
        core_req = 1'b0;
        noise();
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // Read that is reset while waiting for its acknowledge (pipelined instance).
    task automatic reset_in_wait();
        logic [AW-1:0] a;
        a = AW'($urandom);
        next_cycle();
        core_req = 1'b1;  core_we = 1'b0;  core_addr = a;  core_wdata = DW'($urandom);  core_be = '1;
        noise();
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
        m_we = 1'b0;  m_adr = a & ~AW'(SW - 1);  m_dat = core_wdata;  m_sel = '1;
        next_cycle();
        set_slave(1'b0, 1'b0, 1'b0, DW'($urandom));
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
        next_cycle();
        set_slave(1'b0, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
        rst = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
        next_cycle();
        rst = 1'b0;
        core_req = 1'b0;
        set_slave(1'b0, 1'b0, 1'b0, '0);
        model_clear();
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
        next_cycle();
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int            rc, base_stb, base_cyc, base_rdy;
        logic          w;
        logic [SW-1:0] b;
        rst = 1'b1;
        core_req = 1'b0;  core_we = 1'b0;  core_addr = '0;  core_wdata = '0;  core_be = '0;
        set_slave(1'b0, 1'b0, 1'b0, '0);
        model_clear();
        do_reset();

        // classic instance
        pip = 1'b0;
        do_txn(1'b0, 32'h1000_0003, 32'h0, 4'h0, 0, 0, 0, 32'hDEAD_BEEF, rc);
        chk("cl_read_latency", 64'(rdy_cyc - rc), 64'd2);
        chk("cl_read_rdata", 64'(rdy_rdata), 64'hDEAD_BEEF);
        chk("cl_read_err", 64'(rdy_err), 64'd0);
        chk("cl_read_adr", 64'(stb_adr), 64'h1000_0000);
        chk("cl_read_sel", 64'(stb_sel), 64'hF);

        base_cyc = cyc_cnt;
        do_txn(1'b0, 32'h2000_0010, 32'h0, 4'hF, 3, 0, 0, 32'h0, rc);
        chk("cl_timeout_cycles", 64'(cyc_cnt - base_cyc), 64'd8);
        chk("cl_timeout_err", 64'(rdy_err), 64'd1);
        chk("cl_timeout_rdata", 64'(rdy_rdata), 64'd0);

        do_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 2, 1, 0, 32'h1234_5678, rc);
        chk("both_err", 64'(rdy_err), 64'd1);
        chk("both_rdata", 64'(rdy_rdata), 64'd0);

        base_cyc = cyc_cnt;
        do_txn(1'b1, 32'h4000_0008, 32'hCAFE_F00D, 4'h0, 0, 0, 0, 32'h0, rc);
        chk("be0_latency", 64'(rdy_cyc - rc), 64'd1);
        chk("be0_no_cyc", 64'(cyc_cnt - base_cyc), 64'd0);
        chk("be0_err", 64'(rdy_err), 64'd0);

        for (int i = 0; i < 150; i++) begin
            w = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 5) == 0) ? '0 : SW'($urandom);
            do_txn(w, AW'($urandom), DW'($urandom), b, $urandom_range(0, 3), $urandom_range(0, 10),
                   $urandom_range(0, 4), DW'($urandom), rc);
        end

        // pipelined instance
        do_reset();
        pip = 1'b1;
        base_stb = stb_cnt;
        base_cyc = cyc_cnt;
        do_txn(1'b1, 32'h5000_0002, 32'hA5A5_5A5A, 4'h3, 0, 5, 3, 32'hFFFF_FFFF, rc);
        chk("pl_stb_cycles", 64'(stb_cnt - base_stb), 64'd4);
        chk("pl_cyc_cycles", 64'(cyc_cnt - base_cyc), 64'd6);
        chk("pl_ready_after_ack", 64'(rdy_cyc - rc), 64'd7);
        chk("pl_write_rdata", 64'(rdy_rdata), 64'd0);

        base_cyc = cyc_cnt;
        do_txn(1'b0, 32'h6000_0000, 32'h0, 4'hF, 3, 0, 2, 32'h0, rc);
        chk("pl_timeout_cycles", 64'(cyc_cnt - base_cyc), 64'd8);
        chk("pl_timeout_err", 64'(rdy_err), 64'd1);

        base_rdy = rdy_cnt;
        reset_in_wait();
        chk("rst_no_ready", 64'(rdy_cnt - base_rdy), 64'd0);
        do_txn(1'b0, 32'h7000_0001, 32'h0, 4'hF, 0, 1, 0, 32'h0BAD_F00D, rc);
        chk("post_rst_rdata", 64'(rdy_rdata), 64'h0BAD_F00D);
        chk("post_rst_err", 64'(rdy_err), 64'd0);

        for (int i = 0; i < 150; i++) begin
            w = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 5) == 0) ? '0 : SW'($urandom);
            do_txn(w, AW'($urandom), DW'($urandom), b, $urandom_range(0, 3), $urandom_range(0, 10),
                   $urandom_range(0, 4), DW'($urandom), rc);
        end

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
